// File: rtl/irq_pkg.sv
// Shared constants for the interrupt controller: register map, STATUS bit layout
// and the width of a channel index.
`timescale 1ns/1ps
package irq_pkg;

    localparam int ID_W = 5;

    localparam logic [1:0] ADDR_PENDING = 2'd0;
    localparam logic [1:0] ADDR_MASK    = 2'd1;
    localparam logic [1:0] ADDR_MODE    = 2'd2;
    localparam logic [1:0] ADDR_STATUS  = 2'd3;

    localparam int STAT_ID_LSB  = 0;
    localparam int STAT_ISR_LSB = 8;
    localparam int STAT_ISV     = 16;
    localparam int STAT_INT     = 31;

endpackage

// File: rtl/irq_sync.sv
// Multi-bit flop-chain synchroniser for asynchronous request lines.
`timescale 1ns/1ps
module irq_sync #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [DEPTH-1:0][WIDTH-1:0] stage;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stage <= '0;
        end else begin
            stage <= {stage[DEPTH-2:0], d};
        end
    end

    assign q = stage[DEPTH-1];

endmodule

// File: rtl/irq_ctrl.sv
// Fixed-priority interrupt controller with per-channel edge/level mode, masking,
// acknowledge/EOI handshake and a small register interface.
`timescale 1ns/1ps
module irq_ctrl
    import irq_pkg::*;
#(
    parameter int N_IRQ       = 8,
    parameter int SYNC_STAGES = 2
) (
    input  logic             CLK,
    input  logic             RESET_N,
    input  logic [N_IRQ-1:0] IRQ_IN,
    input  logic             WE,
    input  logic [1:0]       ADDR,
    input  logic [31:0]      WD,
    output logic [31:0]      RD,
    input  logic             ACK,
    output logic             INT,
    output logic [ID_W-1:0]  INT_ID
);

    logic [N_IRQ-1:0] s;
    logic [N_IRQ-1:0] s_prev;
    logic [N_IRQ-1:0] pending;
    logic [N_IRQ-1:0] pending_nxt;
    logic [N_IRQ-1:0] mask;
    logic [N_IRQ-1:0] mode;
    logic [N_IRQ-1:0] active;
    logic [N_IRQ-1:0] w1c;
    logic [N_IRQ-1:0] ack_clr;
    logic [N_IRQ-1:0] edge_set;
    logic [ID_W-1:0]  isr_id;
    logic [ID_W-1:0]  win_id;
    logic             isv;
    logic             ack_take;
    logic             eoi;
    logic             unused_wd;

    irq_sync #(
        .WIDTH(N_IRQ),
        .DEPTH(SYNC_STAGES)
    ) u_sync (
        .clk  (CLK),
        .rst_n(RESET_N),
        .d    (IRQ_IN),
        .q    (s)
    );

    assign active    = pending & mask;
    assign ack_take  = ACK & INT;
    assign eoi       = WE && (ADDR == ADDR_STATUS) && WD[STAT_ISV];
    assign w1c       = (WE && (ADDR == ADDR_PENDING)) ? WD[N_IRQ-1:0] : '0;
    assign edge_set  = s & ~s_prev & mode;
    assign unused_wd = ^WD;

    // Lowest index wins, so scan downward and let later hits overwrite.
    always_comb begin
        ack_clr = '0;
        win_id  = '0;
        for (int i = N_IRQ - 1; i >= 0; i--) begin
            ack_clr[i] = ack_take && (INT_ID == ID_W'(i));
            if (active[i]) win_id = ID_W'(i);
        end
    end

    // Edge bits: a fresh edge beats any clear in the same cycle. Level bits follow S.
    assign pending_nxt = (mode & ((pending & ~(w1c | ack_clr)) | edge_set))
                       | (~mode & s);

    always_comb begin
        RD = '0;
        case (ADDR)
            ADDR_PENDING: RD[N_IRQ-1:0] = pending;
            ADDR_MASK:    RD[N_IRQ-1:0] = mask;
            ADDR_MODE:    RD[N_IRQ-1:0] = mode;
            default: begin
                RD[STAT_INT]                = INT;
                RD[STAT_ID_LSB +: ID_W]     = INT_ID;
                RD[STAT_ISR_LSB +: ID_W]    = isr_id;
                RD[STAT_ISV]                = isv;
            end
        endcase
    end

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            s_prev  <= '0;
            pending <= '0;
            mask    <= '0;
            mode    <= '0;
            isr_id  <= '0;
            isv     <= 1'b0;
            INT     <= 1'b0;
            INT_ID  <= '0;
        end else begin
            s_prev  <= s;
            pending <= pending_nxt;
            if (WE && (ADDR == ADDR_MASK)) mask <= WD[N_IRQ-1:0];
            if (WE && (ADDR == ADDR_MODE)) mode <= WD[N_IRQ-1:0];
            if (ack_take) begin
                isr_id <= INT_ID;
                isv    <= 1'b1;
            end else if (eoi) begin
                isv <= 1'b0;
            end
            INT    <= ~ack_take & (|active) & ~isv;
            INT_ID <= win_id;
        end
    end

endmodule

// File: tb/tb_irq_ctrl.sv
// Directed bench for irq_ctrl: expected values queued as stimulus is applied,
// then popped and compared against the DUT outputs.
`timescale 1ns/1ps
module tb_irq_ctrl;

    logic        CLK = 1'b0;
    logic        RESET_N;
    logic [7:0]  IRQ_IN;
    logic        WE;
    logic [1:0]  ADDR;
    logic [31:0] WD;
    logic [31:0] RD;
    logic        ACK;
    logic        INT;
    logic [4:0]  INT_ID;

    irq_ctrl #(.N_IRQ(8), .SYNC_STAGES(2)) dut (
        .CLK    (CLK),
        .RESET_N(RESET_N),
        .IRQ_IN (IRQ_IN),
        .WE     (WE),
        .ADDR   (ADDR),
        .WD     (WD),
        .RD     (RD),
        .ACK    (ACK),
        .INT    (INT),
        .INT_ID (INT_ID)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        string       tag;
        logic [31:0] val;
    } exp_t;

    exp_t sb[$];
    int   errors = 0;
    int   checks = 0;

    task automatic expect_val(input string tag, input logic [31:0] v);
        exp_t e;
        e.tag = tag;
        e.val = v;
        sb.push_back(e);
    endtask

    task automatic check(input logic [31:0] obs);
        exp_t e;
        checks++;
        if (sb.size() == 0) begin
            errors++;
            $error("FAIL scoreboard_empty observed=%h expected=<none>", obs);
        end else begin
            e = sb.pop_front();
            assert (obs === e.val) else begin
                errors++;
                $error("FAIL %s observed=%h expected=%h", e.tag, obs, e.val);
            end
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge CLK);
        #1;
    endtask

    task automatic wr(input logic [1:0] a, input logic [31:0] d);
        ADDR = a;
        WD   = d;
        WE   = 1'b1;
        tick(1);
        WE   = 1'b0;
        WD   = '0;
    endtask

    task automatic rd(input logic [1:0] a, output logic [31:0] v);
        ADDR = a;
        #0.1;
        v = RD;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "bench timed out");
    end

    initial begin
        logic [31:0] v;
        RESET_N = 1'b0;
        IRQ_IN  = '0;
        WE      = 1'b0;
        ADDR    = '0;
        WD      = '0;
        ACK     = 1'b0;
        #1;

        // reset state
        for (int a = 0; a < 4; a++) begin
            expect_val($sformatf("reset_rd%0d", a), 32'h0);
            rd(2'(a), v);
            check(v);
        end
        expect_val("reset_int", 32'h0);
        expect_val("reset_int_id", 32'h0);
        check(INT);
        check(INT_ID);
        tick(2);
        RESET_N = 1'b1;
        tick(1);

        // level channel 3: latency and W1C immunity
        wr(2'd1, 32'hFF);
        wr(2'd2, 32'h00);
        expect_val("mask_rd", 32'hFF);
        rd(2'd1, v);
        check(v);
        IRQ_IN = 8'h08;
        expect_val("lvl_int_early", 32'h0);
        tick(3);
        check(INT);
        expect_val("lvl_int_set", 32'h1);
        expect_val("lvl_int_id3", 32'h3);
        tick(1);
        check(INT);
        check(INT_ID);
        wr(2'd0, 32'h08);
        expect_val("lvl_w1c_ignored", 32'h08);
        rd(2'd0, v);
        check(v);
        expect_val("lvl_status", 32'h8000_0003);
        rd(2'd3, v);
        check(v);
        IRQ_IN = 8'h00;
        expect_val("lvl_int_hold", 32'h1);
        tick(3);
        check(INT);
        expect_val("lvl_int_clr", 32'h0);
        expect_val("lvl_int_id0", 32'h0);
        tick(1);
        check(INT);
        check(INT_ID);

        // edge channel 5: pulse latched, W1C clears, INT follows one edge later
        wr(2'd2, 32'hFF);
        IRQ_IN = 8'h20;
        tick(1);
        IRQ_IN = 8'h00;
        tick(2);
        expect_val("edge_pend_set", 32'h20);
        rd(2'd0, v);
        check(v);
        tick(5);
        expect_val("edge_pend_hold", 32'h20);
        expect_val("edge_int", 32'h1);
        expect_val("edge_int_id5", 32'h5);
        rd(2'd0, v);
        check(v);
        check(INT);
        check(INT_ID);
        wr(2'd0, 32'h20);
        expect_val("w1c_pend", 32'h0);
        expect_val("w1c_int_same_edge", 32'h1);
        rd(2'd0, v);
        check(v);
        check(INT);
        expect_val("w1c_int_next_edge", 32'h0);
        tick(1);
        check(INT);

        // priority, ACK and EOI with channels 2 and 6
        IRQ_IN = 8'h44;
        expect_val("prio_int_early", 32'h0);
        tick(3);
        check(INT);
        expect_val("prio_int", 32'h1);
        expect_val("prio_id2", 32'h2);
        tick(1);
        check(INT);
        check(INT_ID);
        ACK = 1'b1;
        tick(1);
        ACK = 1'b0;
        expect_val("ack_int", 32'h0);
        expect_val("ack_pend", 32'h40);
        expect_val("ack_isv", 32'h1);
        expect_val("ack_isr_id", 32'h2);
        check(INT);
        rd(2'd0, v);
        check(v);
        rd(2'd3, v);
        check(32'(v[16]));
        check(32'(v[12:8]));
        tick(2);
        expect_val("isv_blocks_int", 32'h0);
        check(INT);
        wr(2'd3, 32'h0001_0000);
        expect_val("eoi_int_same_edge", 32'h0);
        expect_val("eoi_isv", 32'h0);
        check(INT);
        rd(2'd3, v);
        check(32'(v[16]));
        expect_val("eoi_int", 32'h1);
        expect_val("eoi_id6", 32'h6);
        tick(1);
        check(INT);
        check(INT_ID);
        ACK = 1'b1;
        tick(1);
        ACK = 1'b0;
        expect_val("ack6_pend", 32'h0);
        expect_val("ack6_isr_id", 32'h6);
        rd(2'd0, v);
        check(v);
        rd(2'd3, v);
        check(32'(v[12:8]));
        wr(2'd3, 32'h0001_0000);
        tick(1);
        ACK = 1'b1;
        tick(1);
        ACK = 1'b0;
        expect_val("ack_idle_isv", 32'h0);
        expect_val("ack_idle_int", 32'h0);
        rd(2'd3, v);
        check(32'(v[16]));
        check(INT);
        IRQ_IN = 8'h00;

        // set beats W1C on the same edge
        IRQ_IN = 8'h02;
        tick(2);
        wr(2'd0, 32'h02);
        expect_val("set_wins", 32'h02);
        rd(2'd0, v);
        check(v);
        wr(2'd0, 32'h02);
        expect_val("w1c_after_set", 32'h0);
        rd(2'd0, v);
        check(v);
        IRQ_IN = 8'h00;

        // masked pending, then unmask
        wr(2'd1, 32'h00);
        IRQ_IN = 8'h10;
        tick(4);
        expect_val("masked_pend", 32'h10);
        expect_val("masked_int", 32'h0);
        rd(2'd0, v);
        check(v);
        check(INT);
        wr(2'd1, 32'h10);
        expect_val("unmask_int_same_edge", 32'h0);
        check(INT);
        expect_val("unmask_int", 32'h1);
        expect_val("unmask_id4", 32'h4);
        tick(1);
        check(INT);
        check(INT_ID);

        // level-to-edge mode change keeps pending
        wr(2'd2, 32'hFE);
        IRQ_IN = 8'h11;
        tick(3);
        expect_val("lvl0_pend", 32'h11);
        rd(2'd0, v);
        check(v);
        IRQ_IN = 8'h10;
        wr(2'd2, 32'hFF);
        tick(4);
        expect_val("mode_switch_keep", 32'h11);
        rd(2'd0, v);
        check(v);

        // reset in the middle of service, line held high across release
        ACK = 1'b1;
        tick(1);
        ACK = 1'b0;
        expect_val("svc_isv", 32'h1);
        rd(2'd3, v);
        check(32'(v[16]));
        RESET_N = 1'b0;
        expect_val("rst_mid_status", 32'h0);
        expect_val("rst_mid_pend", 32'h0);
        expect_val("rst_mid_int", 32'h0);
        rd(2'd3, v);
        check(v);
        rd(2'd0, v);
        check(v);
        check(INT);
        tick(1);
        RESET_N = 1'b1;
        wr(2'd2, 32'hFF);
        tick(1);
        expect_val("rel_pend_early", 32'h0);
        rd(2'd0, v);
        check(v);
        tick(1);
        expect_val("rel_pend_set", 32'h10);
        rd(2'd0, v);
        check(v);
        tick(3);
        expect_val("rel_pend_hold", 32'h10);
        expect_val("rel_isv", 32'h0);
        rd(2'd0, v);
        check(v);
        rd(2'd3, v);
        check(32'(v[16]));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
